// File: rtl/paddle_encoder_ctrl.sv
// Rotary encoder front end for one Pong paddle: sync, debounce,
// quadrature detent decode, saturating position and serve pulse.
module paddle_encoder_ctrl #(
  parameter int DEBOUNCE = 16,
  parameter int POS_W    = 8,
  parameter int POS_MAX  = 200,
  parameter int STEP     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             switch,
  input  logic             centre,
  output logic             up,
  output logic             down,
  output logic             serve,
  output logic [POS_W-1:0] pos
);

  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE - 1);

  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S10 = 2'b10;

  localparam logic [POS_W-1:0] CTR = POS_W'(POS_MAX / 2);
  localparam logic [POS_W:0] MAXV = (POS_W + 1)'(POS_MAX);
  localparam logic [POS_W:0] STEPV = (POS_W + 1)'(STEP);

  // Bit order {a, b, sw} for all three pin pipelines.
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [2:0]    filt;
  logic [CW-1:0] cnt [3];

  logic [1:0] ab;
  logic [1:0] ab_q;
  logic [2:0] sub;
  logic [3:0] inc;
  logic [3:0] sum;
  logic       step_up;
  logic       step_dn;
  logic       enter;
  logic       sw_q;

  logic [POS_W:0] pos_x;
  logic [POS_W:0] pos_up;
  logic [POS_W:0] pos_dn;

  function automatic logic [1:0] next_up(input logic [1:0] s);
    case (s)
      S11:     next_up = S01;
      S01:     next_up = S00;
      S00:     next_up = S10;
      default: next_up = S11;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '1;
      s2   <= '1;
      filt <= '1;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= {in_a, in_b, switch};
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] != filt[i]) begin
          if (cnt[i] == CNT_TOP) begin
            filt[i] <= s2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign ab      = filt[2:1];
  assign step_up = (ab == next_up(ab_q));
  assign step_dn = (ab_q == next_up(ab));
  assign enter   = (ab == S11) && (ab_q != S11);

  always_comb begin
    inc = 4'b0000;
    unique case (1'b1)
      step_up: inc = 4'b0001;
      step_dn: inc = 4'b1111;
      default: inc = 4'b0000;
    endcase
  end

  // Substep is sign-extended so a full turn reads +4 / -4.
  assign sum = {sub[2], sub} + inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_q <= S11;
      sub  <= '0;
      up   <= 1'b0;
      down <= 1'b0;
    end else begin
      ab_q <= ab;
      up   <= 1'b0;
      down <= 1'b0;
      if (centre) begin
        sub <= '0;
      end else if (enter) begin
        up   <= (sum == 4'b0100);
        down <= (sum == 4'b1100);
        sub  <= '0;
      end else begin
        sub <= sum[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q  <= 1'b1;
      serve <= 1'b0;
    end else begin
      sw_q  <= filt[0];
      serve <= sw_q & ~filt[0];
    end
  end

  assign pos_x  = {1'b0, pos};
  assign pos_up = pos_x + STEPV;
  assign pos_dn = pos_x - STEPV;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= CTR;
    end else if (centre) begin
      pos <= CTR;
    end else if (up) begin
      pos <= (pos_up > MAXV) ? MAXV[POS_W-1:0] : pos_up[POS_W-1:0];
    end else if (down) begin
      pos <= (pos_x < STEPV) ? '0 : pos_dn[POS_W-1:0];
    end
  end

endmodule
